// File: rtl/id_stage_hz_pkg.sv
// id_pkg: instruction field positions and the NOP encoding shared by the decode stage.
package id_pkg;
    localparam int RS_MSB  = 25;
    localparam int RS_LSB  = 21;
    localparam int RT_MSB  = 20;
    localparam int RT_LSB  = 16;
    localparam int RD_MSB  = 15;
    localparam int RD_LSB  = 11;
    localparam int IMM_MSB = 15;
    localparam int IMM_LSB = 0;
    localparam logic [31:0] NOP_INSTR = 32'h0;
endpackage

// File: rtl/id_stage_hz_if.sv
// id_stage_hz_if: IF/ID, EX feedback, WB write port and ID/EX outputs of the decode stage.
interface id_stage_hz_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int CNT_WIDTH  = 16
);
    logic                  if_valid;
    logic [DATA_WIDTH-1:0] instr_in;
    logic [DATA_WIDTH-1:0] pc_plus4_in;
    logic                  ext_ctrl;
    logic                  if_flush;
    logic                  ex_hold;
    logic                  ex_mem_read;
    logic [ADDR_WIDTH-1:0] ex_rt_addr;
    logic                  reg_wr_en;
    logic [ADDR_WIDTH-1:0] reg_wr_addr;
    logic [DATA_WIDTH-1:0] reg_wr_data;
    logic                  id_stall;
    logic                  valid_out;
    logic [DATA_WIDTH-1:0] pc_plus4_out;
    logic [DATA_WIDTH-1:0] regA_rd_data;
    logic [DATA_WIDTH-1:0] regB_rd_data;
    logic [DATA_WIDTH-1:0] imm_exted;
    logic [ADDR_WIDTH-1:0] regS_addr;
    logic [ADDR_WIDTH-1:0] regT_addr;
    logic [ADDR_WIDTH-1:0] regD_addr;
    logic [CNT_WIDTH-1:0]  hz_count;
    modport master (
        output if_valid, instr_in, pc_plus4_in, ext_ctrl, if_flush, ex_hold, ex_mem_read,
               ex_rt_addr, reg_wr_en, reg_wr_addr, reg_wr_data,
        input  id_stall, valid_out, pc_plus4_out, regA_rd_data, regB_rd_data, imm_exted,
               regS_addr, regT_addr, regD_addr, hz_count
    );
    modport slave (
        input  if_valid, instr_in, pc_plus4_in, ext_ctrl, if_flush, ex_hold, ex_mem_read,
               ex_rt_addr, reg_wr_en, reg_wr_addr, reg_wr_data,
        output id_stall, valid_out, pc_plus4_out, regA_rd_data, regB_rd_data, imm_exted,
               regS_addr, regT_addr, regD_addr, hz_count
    );
endinterface

// File: rtl/id_stage_hz_regfile.sv
// regfile_2r1w: 2-read/1-write register file with hard-wired zero register.
// RF_BYPASS_EN: when defined, a same-cycle write is forwarded to a matching read port.
module regfile_2r1w #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
) (
    input  logic                  clk,
    input  logic                  rstb,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic [ADDR_WIDTH-1:0] ra_a,
    input  logic [ADDR_WIDTH-1:0] ra_b,
    output logic [DATA_WIDTH-1:0] rd_a,
    output logic [DATA_WIDTH-1:0] rd_b
);
    logic [DATA_WIDTH-1:0] mem_q [2**ADDR_WIDTH];
    logic [DATA_WIDTH-1:0] mem_d [2**ADDR_WIDTH];
    logic                  byp_a, byp_b;

    always_comb begin
        mem_d = mem_q;
        if (wr_en && wr_addr != '0) mem_d[wr_addr] = wr_data;
    end

    always_ff @(posedge clk) begin
        if (!rstb) mem_q <= '{default: '0};
        else       mem_q <= mem_d;
    end

`ifdef RF_BYPASS_EN
    assign byp_a = wr_en && wr_addr != '0 && wr_addr == ra_a;
    assign byp_b = wr_en && wr_addr != '0 && wr_addr == ra_b;
`else
    assign byp_a = 1'b0;
    assign byp_b = 1'b0;
`endif

    assign rd_a = (ra_a == '0) ? '0 : byp_a ? wr_data : mem_q[ra_a];
    assign rd_b = (ra_b == '0) ? '0 : byp_b ? wr_data : mem_q[ra_b];
endmodule

// File: rtl/id_stage_hz.sv
// id_stage_hz: decode stage with load-use bubble, EX hold, sticky flush and hazard counter.
// RF_BYPASS_EN selects write-through forwarding inside the register file.
module id_stage_hz
    import id_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int CNT_WIDTH  = 16
) (
    input logic          clk,
    input logic          rstb,
    id_stage_hz_if.slave bus
);
    logic [DATA_WIDTH-1:0] instr_eff, rd_a, rd_b, imm_ext;
    logic [ADDR_WIDTH-1:0] rs, rt, rd;
    logic                  hz, bubble, unused_ok;
    logic                  valid_q, valid_d, flush_pend_q, flush_pend_d;
    logic [DATA_WIDTH-1:0] pc_q, pc_d, a_q, a_d, b_q, b_d, imm_q, imm_d;
    logic [ADDR_WIDTH-1:0] s_q, s_d, t_q, t_d, d_q, d_d;
    logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;

    assign instr_eff = (bus.if_flush | ~bus.if_valid) ? DATA_WIDTH'(NOP_INSTR) : bus.instr_in;
    assign rs        = ADDR_WIDTH'(instr_eff[RS_MSB:RS_LSB]);
    assign rt        = ADDR_WIDTH'(instr_eff[RT_MSB:RT_LSB]);
    assign rd        = ADDR_WIDTH'(instr_eff[RD_MSB:RD_LSB]);
    assign imm_ext   = bus.ext_ctrl
                     ? {{(DATA_WIDTH-16){instr_eff[IMM_MSB]}}, instr_eff[IMM_MSB:IMM_LSB]}
                     : {{(DATA_WIDTH-16){1'b0}}, instr_eff[IMM_MSB:IMM_LSB]};
    assign unused_ok = ^instr_eff[DATA_WIDTH-1:RS_MSB+1];

    regfile_2r1w #(.DATA_WIDTH(DATA_WIDTH), .ADDR_WIDTH(ADDR_WIDTH)) u_rf (
        .clk    (clk),
        .rstb   (rstb),
        .wr_en  (bus.reg_wr_en),
        .wr_addr(bus.reg_wr_addr),
        .wr_data(bus.reg_wr_data),
        .ra_a   (rs),
        .ra_b   (rt),
        .rd_a   (rd_a),
        .rd_b   (rd_b)
    );

    // A held EX keeps its load, so the load-use check only matters once EX moves.
    assign hz = bus.ex_mem_read & ~bus.ex_hold & bus.if_valid & ~bus.if_flush &
                (bus.ex_rt_addr != '0) & (bus.ex_rt_addr == rs | bus.ex_rt_addr == rt);
    assign bus.id_stall = hz | bus.ex_hold;

    always_comb begin
        bubble       = flush_pend_q | bus.if_flush | hz | ~bus.if_valid;
        flush_pend_d = bus.ex_hold & (flush_pend_q | bus.if_flush);
        cnt_d        = (hz && cnt_q != '1) ? cnt_q + CNT_WIDTH'(1) : cnt_q;
        valid_d      = bus.ex_hold ? valid_q : ~bubble;
        pc_d         = bus.ex_hold ? pc_q  : bubble ? '0 : bus.pc_plus4_in;
        a_d          = bus.ex_hold ? a_q   : bubble ? '0 : rd_a;
        b_d          = bus.ex_hold ? b_q   : bubble ? '0 : rd_b;
        imm_d        = bus.ex_hold ? imm_q : bubble ? '0 : imm_ext;
        s_d          = bus.ex_hold ? s_q   : bubble ? '0 : rs;
        t_d          = bus.ex_hold ? t_q   : bubble ? '0 : rt;
        d_d          = bus.ex_hold ? d_q   : bubble ? '0 : rd;
    end

    always_ff @(posedge clk) begin
        if (!rstb) begin
            valid_q      <= 1'b0;
            flush_pend_q <= 1'b0;
            cnt_q        <= '0;
            pc_q         <= '0;
            a_q          <= '0;
            b_q          <= '0;
            imm_q        <= '0;
            s_q          <= '0;
            t_q          <= '0;
            d_q          <= '0;
        end else begin
            valid_q      <= valid_d;
            flush_pend_q <= flush_pend_d;
            cnt_q        <= cnt_d;
            pc_q         <= pc_d;
            a_q          <= a_d;
            b_q          <= b_d;
            imm_q        <= imm_d;
            s_q          <= s_d;
            t_q          <= t_d;
            d_q          <= d_d;
        end
    end

    assign bus.valid_out    = valid_q;
    assign bus.pc_plus4_out = pc_q;
    assign bus.regA_rd_data = a_q;
    assign bus.regB_rd_data = b_q;
    assign bus.imm_exted    = imm_q;
    assign bus.regS_addr    = s_q;
    assign bus.regT_addr    = t_q;
    assign bus.regD_addr    = d_q;
    assign bus.hz_count     = cnt_q;
endmodule

// File: tb/tb_id_stage_hz.sv
// tb_id_stage_hz: directed vectors with a queued scoreboard for the decode stage.
// Counter width is reduced so saturation is reached quickly.
module tb_id_stage_hz;
    localparam int DW = 32;
    localparam int AW = 5;
    localparam int CW = 4;
`ifdef RF_BYPASS_EN
    localparam logic [31:0] BYP = 32'h0000_A5A5;
`else
    localparam logic [31:0] BYP = 32'h0;
`endif

    typedef struct {
        logic          stall;
        logic          valid;
        logic [31:0]   a, b, imm, pc;
        logic [4:0]    s, t, d;
        logic [CW-1:0] cnt;
    } exp_t;

    logic clk = 1'b0;
    logic rstb = 1'b0;
    logic stall_s;
    exp_t q[$];
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    id_stage_hz_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .CNT_WIDTH(CW)) bus ();
    id_stage_hz #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .CNT_WIDTH(CW)) dut (
        .clk (clk),
        .rstb(rstb),
        .bus (bus)
    );

    function automatic logic [31:0] enc(logic [4:0] rs, logic [4:0] rt, logic [15:0] imm);
        return {6'd0, rs, rt, imm};
    endfunction

    function automatic exp_t mk(logic st, logic v, logic [31:0] ins, logic [31:0] a,
                                logic [31:0] b, logic [31:0] imm, logic [31:0] pc,
                                logic [CW-1:0] cnt);
        exp_t e;
        e.stall = st; e.valid = v; e.a = a; e.b = b; e.imm = imm; e.pc = pc; e.cnt = cnt;
        e.s = ins[25:21]; e.t = ins[20:16]; e.d = ins[15:11];
        return e;
    endfunction

    function automatic exp_t bub(logic st, logic [CW-1:0] cnt);
        return mk(st, 1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, cnt);
    endfunction

    task automatic drive(input logic rb, input logic v, input logic [31:0] ins,
                         input logic [31:0] pc, input logic ext, input logic fl,
                         input logic hold, input logic mr, input logic [4:0] rta,
                         input logic we, input logic [4:0] wa, input logic [31:0] wd,
                         input exp_t e);
        @(negedge clk);
        rstb = rb;
        bus.if_valid = v; bus.instr_in = ins; bus.pc_plus4_in = pc; bus.ext_ctrl = ext;
        bus.if_flush = fl; bus.ex_hold = hold; bus.ex_mem_read = mr; bus.ex_rt_addr = rta;
        bus.reg_wr_en = we; bus.reg_wr_addr = wa; bus.reg_wr_data = wd;
        q.push_back(e);
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Combinational stall is sampled late in the cycle, just before the edge it affects.
    always @(negedge clk) begin
        #4 stall_s = bus.id_stall;
    end

    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() != 0) begin
                e = q.pop_front();
                chk("id_stall", {31'd0, stall_s}, {31'd0, e.stall});
                chk("valid_out", {31'd0, bus.valid_out}, {31'd0, e.valid});
                chk("regA_rd_data", bus.regA_rd_data, e.a);
                chk("regB_rd_data", bus.regB_rd_data, e.b);
                chk("imm_exted", bus.imm_exted, e.imm);
                chk("pc_plus4_out", bus.pc_plus4_out, e.pc);
                chk("regS_addr", {27'd0, bus.regS_addr}, {27'd0, e.s});
                chk("regT_addr", {27'd0, bus.regT_addr}, {27'd0, e.t});
                chk("regD_addr", {27'd0, bus.regD_addr}, {27'd0, e.d});
                chk("hz_count", {28'd0, bus.hz_count}, {28'd0, e.cnt});
            end
        end
    end

    initial begin
        exp_t held;
        logic [31:0] i_ld, i_h, i_z, i_b;
        i_ld = enc(5'd5, 5'd3, 16'h0803);
        i_h  = enc(5'd5, 5'd5, 16'h0008);
        i_z  = enc(5'd0, 5'd0, 16'h8001);
        i_b  = enc(5'd7, 5'd9, 16'h0000);
        // reset wins over a valid instruction and a write to r9
        drive(0, 1, enc(5'd5, 5'd0, 16'h10), 32'h100, 0, 0, 0, 0, 0, 1, 5'd9, 32'hDEAD, bub(0, 0));
        drive(1, 0, 32'h0, 32'h0, 0, 0, 0, 0, 0, 1, 5'd5, 32'h1234, bub(0, 0));
        drive(1, 1, enc(5'd5, 5'd0, 16'h10), 32'h104, 0, 0, 0, 0, 0, 1, 5'd3, 32'h33,
              mk(0, 1, enc(5'd5, 5'd0, 16'h10), 32'h1234, 32'h0, 32'h10, 32'h104, 0));
        // load-use on rs: one bubble, then the same instruction issues
        drive(1, 1, i_ld, 32'h108, 0, 0, 0, 1, 5'd5, 0, 5'd0, 32'h0, bub(1, 1));
        drive(1, 1, i_ld, 32'h108, 0, 0, 0, 0, 5'd0, 0, 5'd0, 32'h0,
              mk(0, 1, i_ld, 32'h1234, 32'h33, 32'h803, 32'h108, 1));
        held = mk(0, 1, enc(5'd3, 5'd5, 16'h4), 32'h33, 32'h1234, 32'h4, 32'h10C, 1);
        drive(1, 1, enc(5'd3, 5'd5, 16'h4), 32'h10C, 0, 0, 0, 0, 5'd0, 0, 5'd0, 32'h0, held);
        held.stall = 1'b1;
        // hold for three cycles, flush pulse in the second; a load in EX is ignored while held
        drive(1, 1, i_h, 32'h110, 0, 0, 1, 1, 5'd5, 0, 5'd0, 32'h0, held);
        drive(1, 1, i_h, 32'h110, 0, 1, 1, 0, 5'd0, 0, 5'd0, 32'h0, held);
        drive(1, 1, i_h, 32'h110, 0, 0, 1, 0, 5'd0, 0, 5'd0, 32'h0, held);
        drive(1, 1, i_h, 32'h110, 0, 0, 0, 0, 5'd0, 0, 5'd0, 32'h0, bub(0, 1));
        drive(1, 1, i_h, 32'h110, 0, 0, 0, 0, 5'd0, 0, 5'd0, 32'h0,
              mk(0, 1, i_h, 32'h1234, 32'h1234, 32'h8, 32'h110, 1));
        // r0 write discarded; load targeting r0 does not stall; immediate extension
        drive(1, 0, 32'h0, 32'h0, 0, 0, 0, 0, 5'd0, 1, 5'd0, 32'hFFFF_FFFF, bub(0, 1));
        drive(1, 1, i_z, 32'h114, 1, 0, 0, 1, 5'd0, 0, 5'd0, 32'h0,
              mk(0, 1, i_z, 32'h0, 32'h0, 32'hFFFF_8001, 32'h114, 1));
        drive(1, 1, i_z, 32'h114, 0, 0, 0, 0, 5'd0, 0, 5'd0, 32'h0,
              mk(0, 1, i_z, 32'h0, 32'h0, 32'h0000_8001, 32'h114, 1));
        // same-cycle write of r7; r9 stayed 0 because its write happened under reset
        drive(1, 1, i_b, 32'h118, 0, 0, 0, 0, 5'd0, 1, 5'd7, 32'hA5A5,
              mk(0, 1, i_b, BYP, 32'h0, 32'h0, 32'h118, 1));
        drive(1, 1, i_b, 32'h11C, 0, 0, 0, 0, 5'd0, 0, 5'd0, 32'h0,
              mk(0, 1, i_b, 32'hA5A5, 32'h0, 32'h0, 32'h11C, 1));
        // flushed or invalid slots never raise a hazard
        drive(1, 1, enc(5'd7, 5'd0, 16'h0), 32'h120, 0, 1, 0, 1, 5'd7, 0, 5'd0, 32'h0, bub(0, 1));
        drive(1, 0, enc(5'd7, 5'd0, 16'h0), 32'h120, 0, 0, 0, 1, 5'd7, 0, 5'd0, 32'h0, bub(0, 1));
        // hazards through rt drive the counter into saturation
        for (int k = 1; k <= 17; k++)
            drive(1, 1, enc(5'd0, 5'd7, 16'h0), 32'h124, 0, 0, 0, 1, 5'd7, 0, 5'd0, 32'h0,
                  bub(1, (k + 1 > 15) ? CW'(15) : CW'(k + 1)));
        drive(1, 1, enc(5'd3, 5'd5, 16'h4), 32'h128, 0, 0, 0, 0, 5'd0, 0, 5'd0, 32'h0,
              mk(0, 1, enc(5'd3, 5'd5, 16'h4), 32'h33, 32'h1234, 32'h4, 32'h128, 15));
        // reset during a hold with a flush pending clears everything
        drive(0, 1, enc(5'd3, 5'd5, 16'h4), 32'h12C, 0, 1, 1, 0, 5'd0, 0, 5'd0, 32'h0, bub(1, 0));
        drive(1, 1, enc(5'd3, 5'd5, 16'h4), 32'h12C, 0, 0, 0, 0, 5'd0, 0, 5'd0, 32'h0,
              mk(0, 1, enc(5'd3, 5'd5, 16'h4), 32'h0, 32'h0, 32'h4, 32'h12C, 0));
        repeat (3) @(posedge clk);
        #2;
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
